// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_fifo : byte FIFO draining into an 8N1, LSB-first UART serializer.  |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic                          tx_en,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int                 c_AW   = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0]      c_FULL = FIFO_DEPTH[c_AW:0];

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]      r_wr_ptr;
  logic [c_AW-1:0]      r_rd_ptr;
  logic [c_AW:0]        r_count;
  logic                 r_overflow;

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic                 r_tx;
  logic                 r_tx_busy;
  logic [7:0]           r_shift;
  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic [2:0]           r_bit_idx;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_end;
  logic                 w_can_start;
  logic                 w_tx_next;
  logic                 w_busy_next;
  logic [7:0]           w_shift_next;

  assign fifo_full  = (r_count == c_FULL);
  assign fifo_empty = (r_count == '0);
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign tx         = r_tx;
  assign tx_busy    = r_tx_busy;

  // A pop in the same cycle never makes room for a push into a full FIFO.
  assign w_push      = wr_en && !fifo_full;
  assign w_bit_end   = (r_div_cnt == '0);
  assign w_can_start = tx_en && !fifo_empty;

  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_en && fifo_full;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // State register; also registers every serializer output.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_tx_busy <= 1'b0;
      r_shift   <= '0;
      r_div_cnt <= '0;
      r_bit_idx <= '0;
    end else begin
      r_state   <= w_state_next;
      r_tx      <= w_tx_next;
      r_tx_busy <= w_busy_next;
      r_shift   <= w_shift_next;
      // baud_div is re-sampled at the start of every bit period.
      if (r_state == S_IDLE || w_bit_end) begin
        r_div_cnt <= baud_div;
      end else begin
        r_div_cnt <= r_div_cnt - 1'b1;
      end
      if (r_state == S_START) begin
        r_bit_idx <= '0;
      end else if (r_state == S_DATA && w_bit_end) begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_can_start) begin
          w_state_next = S_START;
          w_pop        = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end && r_bit_idx == 3'd7) begin
          w_state_next = S_STOP;
        end
      end
      default: begin
        if (w_bit_end) begin
          if (w_can_start) begin
            w_state_next = S_START;
            w_pop        = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    w_shift_next = r_shift;
    if (w_pop) begin
      w_shift_next = r_mem[r_rd_ptr];
    end else if (r_state == S_DATA && w_bit_end) begin
      w_shift_next = {1'b0, r_shift[7:1]};
    end
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
    w_busy_next = (w_state_next != S_IDLE);
  end

endmodule
`default_nettype wire
